// File: rtl/risc_pkg.sv
// risc_pkg: shared register-file widths, zero-register address and operand typedefs
package risc_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 4;
    localparam int REG_ZERO = 0;
    typedef logic [DATA_W_DEF-1:0] reg_data_t;
    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
endpackage

// File: rtl/risc_scoreboard.sv
// risc_scoreboard: per-register pending bits, reserve beats release, optional hardwired-zero r0
module risc_scoreboard
    import risc_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    localparam int DEPTH = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    output logic [DEPTH-1:0]  busy_vec
);
    logic [DEPTH-1:0] busy, busy_nxt;
    // release on writeback first so a same-register reserve overrides it
    always_comb begin
        busy_nxt = busy;
        if (wr_en) busy_nxt[wr_addr] = 1'b0;
        if (rsv_en) busy_nxt[rsv_addr] = 1'b1;
        if (ZERO_REG != 0) busy_nxt[REG_ZERO] = 1'b0;
    end
    // scoreboard state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) busy <= '0;
        else busy <= busy_nxt;
    end
    assign busy_vec = busy;
endmodule

// File: rtl/risc_regfile_sb.sv
// risc_regfile_sb: multi-port registered-read register file with write bypass and busy scoreboard
module risc_regfile_sb
    import risc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2,
    parameter int ZERO_REG = 1,
    localparam int DEPTH = 2**ADDR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic [DEPTH-1:0]         busy_vec
);
    logic [DATA_W-1:0]        mem [DEPTH];
    logic [NUM_RD*DATA_W-1:0] data_nxt;
    logic [NUM_RD-1:0]        busy_nxt;

    risc_scoreboard #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_sb (
        .clk(clk),
        .reset(reset),
        .rsv_en(rsv_en),
        .rsv_addr(rsv_addr),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .busy_vec(busy_vec)
    );

    // storage array; writes to a hardwired zero register are dropped
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
        end else if (wr_en && !(ZERO_REG != 0 && int'(wr_addr) == REG_ZERO)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // per-port operand select: zero register, then writeback bypass, then array
    always_comb begin
        data_nxt = '0;
        busy_nxt = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            logic [ADDR_W-1:0] a;
            logic z, h;
            a = rd_addr[i*ADDR_W +: ADDR_W];
            z = ZERO_REG != 0 && int'(a) == REG_ZERO;
            h = wr_en && wr_addr == a;
            data_nxt[i*DATA_W +: DATA_W] = z ? '0 : h ? wr_data : mem[a];
            busy_nxt[i] = !z && !h && busy_vec[a];
        end
    end

    // read registers load only on rd_en
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
            rd_busy <= '0;
        end else if (rd_en) begin
            rd_data <= data_nxt;
            rd_busy <= busy_nxt;
        end
    end
endmodule

// File: tb/tb_risc_regfile_sb.sv
// tb_risc_regfile_sb: vector table, reset/zero-register/sweep sequences and random model check
module tb_risc_regfile_sb;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic re0 = 0, we0 = 0, se0 = 0;
    logic [7:0] ra0 = 0;
    logic [3:0] wa0 = 0, sa0 = 0;
    logic [15:0] wd0 = 0;
    logic [31:0] rd0;
    logic [1:0] rb0;
    logic [15:0] bv0;

    logic re1 = 0, we1 = 0, se1 = 0;
    logic [7:0] ra1 = 0;
    logic [3:0] wa1 = 0, sa1 = 0;
    logic [15:0] wd1 = 0;
    logic [31:0] rd1;
    logic [1:0] rb1;
    logic [15:0] bv1;

    logic re2 = 0, we2 = 0, se2 = 0;
    logic [14:0] ra2 = 0;
    logic [4:0] wa2 = 0, sa2 = 0;
    logic [31:0] wd2 = 0;
    logic [95:0] rd2;
    logic [2:0] rb2;
    logic [31:0] bv2;

    risc_regfile_sb u0 (
        .clk(clk), .reset(rst), .rd_en(re0), .rd_addr(ra0), .rd_data(rd0), .rd_busy(rb0),
        .wr_en(we0), .wr_addr(wa0), .wr_data(wd0), .rsv_en(se0), .rsv_addr(sa0), .busy_vec(bv0)
    );
    risc_regfile_sb #(.ZERO_REG(0)) u1 (
        .clk(clk), .reset(rst), .rd_en(re1), .rd_addr(ra1), .rd_data(rd1), .rd_busy(rb1),
        .wr_en(we1), .wr_addr(wa1), .wr_data(wd1), .rsv_en(se1), .rsv_addr(sa1), .busy_vec(bv1)
    );
    risc_regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3)) u2 (
        .clk(clk), .reset(rst), .rd_en(re2), .rd_addr(ra2), .rd_data(rd2), .rd_busy(rb2),
        .wr_en(we2), .wr_addr(wa2), .wr_data(wd2), .rsv_en(se2), .rsv_addr(sa2), .busy_vec(bv2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic we; logic [3:0] wa; logic [15:0] wd;
        logic se; logic [3:0] sa;
        logic re; logic [3:0] r0; logic [3:0] r1;
        logic [15:0] e0; logic [15:0] e1; logic [1:0] eb; logic [15:0] ebv;
    } vec_t;
    vec_t tbl [15];

    logic [15:0] mem_m [16];
    logic [15:0] busy_m;
    logic [15:0] rdm [2];
    logic [1:0] rbm;

    task automatic model_step();
        logic [3:0] a;
        if (re0) begin
            for (int i = 0; i < 2; i++) begin
                a = ra0[i*4 +: 4];
                if (a == 0) begin
                    rdm[i] = 16'h0;
                    rbm[i] = 1'b0;
                end else if (we0 && wa0 == a) begin
                    rdm[i] = wd0;
                    rbm[i] = 1'b0;
                end else begin
                    rdm[i] = mem_m[a];
                    rbm[i] = busy_m[a];
                end
            end
        end
        if (we0 && wa0 != 0) mem_m[wa0] = wd0;
        if (we0) busy_m[wa0] = 1'b0;
        if (se0 && sa0 != 0) busy_m[sa0] = 1'b1;
        tick();
        chk("rnd_data", 96'(rd0), 96'({rdm[1], rdm[0]}));
        chk("rnd_busy", 96'(rb0), 96'(rbm));
        chk("rnd_bvec", 96'(bv0), 96'(busy_m));
    endtask

    initial begin
        tbl[0]  = '{1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 16'h0000, 16'h0000, 2'b00, 16'h0000};
        tbl[1]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b1, 4'd3, 4'd3, 16'h1234, 16'h1234, 2'b00, 16'h0000};
        tbl[2]  = '{1'b1, 4'd2, 16'h0042, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 16'h1234, 16'h1234, 2'b00, 16'h0000};
        tbl[3]  = '{1'b1, 4'd7, 16'hA5A5, 1'b0, 4'd0, 1'b1, 4'd7, 4'd2, 16'hA5A5, 16'h0042, 2'b00, 16'h0000};
        tbl[4]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b1, 4'd7, 4'd0, 16'hA5A5, 16'h0000, 2'b00, 16'h0000};
        tbl[5]  = '{1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd0, 1'b1, 4'd0, 4'd0, 16'h0000, 16'h0000, 2'b00, 16'h0000};
        tbl[6]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd4, 1'b1, 4'd3, 4'd3, 16'h1234, 16'h1234, 2'b00, 16'h0010};
        tbl[7]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b1, 4'd4, 4'd3, 16'h0000, 16'h1234, 2'b01, 16'h0010};
        tbl[8]  = '{1'b1, 4'd4, 16'h0009, 1'b0, 4'd0, 1'b1, 4'd4, 4'd4, 16'h0009, 16'h0009, 2'b00, 16'h0000};
        tbl[9]  = '{1'b1, 4'd6, 16'h0077, 1'b1, 4'd6, 1'b1, 4'd6, 4'd6, 16'h0077, 16'h0077, 2'b00, 16'h0040};
        tbl[10] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b1, 4'd6, 4'd4, 16'h0077, 16'h0009, 2'b01, 16'h0040};
        tbl[11] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd6, 1'b0, 4'd0, 4'd0, 16'h0077, 16'h0009, 2'b01, 16'h0040};
        tbl[12] = '{1'b1, 4'd6, 16'h0088, 1'b0, 4'd0, 1'b1, 4'd6, 4'd6, 16'h0088, 16'h0088, 2'b00, 16'h0000};
        tbl[13] = '{1'b1, 4'd9, 16'h0099, 1'b1, 4'd1, 1'b1, 4'd9, 4'd1, 16'h0099, 16'h0000, 2'b00, 16'h0002};
        tbl[14] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd2, 1'b1, 4'd1, 4'd9, 16'h0000, 16'h0099, 2'b01, 16'h0006};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", 96'(rd0), 96'h0);
        chk("rst_bvec", 96'(bv0), 96'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 15; i++) begin
            we0 = tbl[i].we; wa0 = tbl[i].wa; wd0 = tbl[i].wd;
            se0 = tbl[i].se; sa0 = tbl[i].sa;
            re0 = tbl[i].re; ra0 = {tbl[i].r1, tbl[i].r0};
            tick();
            chk($sformatf("vec%0d_d0", i), 96'(rd0[15:0]), 96'(tbl[i].e0));
            chk($sformatf("vec%0d_d1", i), 96'(rd0[31:16]), 96'(tbl[i].e1));
            chk($sformatf("vec%0d_rb", i), 96'(rb0), 96'(tbl[i].eb));
            chk($sformatf("vec%0d_bv", i), 96'(bv0), 96'(tbl[i].ebv));
        end

        we0 = 1; wa0 = 4'd5; wd0 = 16'hBEEF; se0 = 0; re0 = 0;
        tick();
        we0 = 0;
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst_data", 96'(rd0), 96'h0);
        chk("async_rst_bvec", 96'(bv0), 96'h0);
        chk("async_rst_busy", 96'(rb0), 96'h0);
        tick();
        chk("rst_held_bvec", 96'(bv0), 96'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int k = 0; k < 16; k++) mem_m[k] = 16'h0;
        busy_m = 16'h0;
        rdm[0] = 16'h0;
        rdm[1] = 16'h0;
        rbm = 2'b00;
        re0 = 1; ra0 = {4'd5, 4'd5};
        model_step();
        chk("r5_after_rst", 96'(rd0), 96'h0);

        for (int n = 0; n < 400; n++) begin
            we0 = 1'($urandom_range(0, 1));
            wa0 = 4'($urandom_range(0, 15));
            wd0 = 16'($urandom);
            se0 = 1'($urandom_range(0, 2) == 0);
            sa0 = 4'($urandom_range(0, 15));
            re0 = 1'($urandom_range(0, 3) != 0);
            ra0 = 8'($urandom);
            if ($urandom_range(0, 3) == 0) ra0[3:0] = wa0;
            if ($urandom_range(0, 3) == 0) ra0[7:4] = sa0;
            model_step();
        end
        we0 = 0; se0 = 0; re0 = 0;

        we1 = 1; wa1 = 4'd0; wd1 = 16'hFFFF; se1 = 1; sa1 = 4'd0;
        tick();
        we1 = 0; se1 = 0; re1 = 1; ra1 = 8'h00;
        tick();
        re1 = 0;
        chk("nozero_data", 96'(rd1), 96'hFFFF_FFFF);
        chk("nozero_busy", 96'(rb1), 96'h3);
        chk("nozero_bvec", 96'(bv1), 96'h1);

        we2 = 1; wa2 = 5'd31; wd2 = 32'hDEADBEEF;
        tick();
        we2 = 0; re2 = 1; ra2 = {5'd31, 5'd31, 5'd31}; se2 = 1; sa2 = 5'd31;
        tick();
        re2 = 0; se2 = 0;
        chk("wide_data", rd2, {3{32'hDEADBEEF}});
        chk("wide_busy", 96'(rb2), 96'h0);
        chk("wide_bvec", 96'(bv2), 96'h8000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/risc_regfile_sb.md
Name: risc_regfile_sb

Overview:
Parametrised next-generation register file for the RISC datapath. It provides a configurable number of registered read ports and one write port with write-to-read bypass. Reads are independent of write enable. An optional hardwired-zero register 0 is included, along with a per-register busy scoreboard that the issue stage uses for RAW hazard detection. It sits between decode/issue (read, reserve) and writeback (write, release).

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 4, register address width; DEPTH = 2**ADDR_W registers
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 always reads 0; writes and reserves to it are ignored

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
rd_en  input  1  read strobe shared by all read ports
rd_addr  input  NUM_RD*ADDR_W  read addresses; port i = bits [i*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  registered read data; port i = [i*DATA_W +: DATA_W]
rd_busy  output  NUM_RD  registered busy flag of each read operand
wr_en  input  1  writeback strobe
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
rsv_en  input  1  reserve strobe from issue: mark destination pending
rsv_addr  input  ADDR_W  register to reserve
busy_vec  output  DEPTH  live scoreboard, bit k = register k pending

Behaviour:
- Reset (reset=0, async): all DEPTH registers = 0, rd_data = 0, rd_busy = 0, busy_vec = 0. Held while reset=0. Any in-flight read or write in that cycle is discarded.
- Write: on posedge with wr_en=1, mem[wr_addr] <= wr_data. Ignored when ZERO_REG=1 and wr_addr=0.
- Read, 1-cycle latency: on posedge with rd_en=1, for each port i with a = rd_addr[i]:
  - rd_data[i] <= 0 if ZERO_REG=1 and a=0.
  - Otherwise rd_data[i] <= wr_data if wr_en=1 and wr_addr=a (bypass).
  - Otherwise rd_data[i] <= mem[a].
- rd_en=0: rd_data and rd_busy hold their previous values. Writes are unaffected by rd_en.
- Multiple ports may read the same address in one cycle; all receive identical data.
- Scoreboard, per register k, on posedge:
  - rsv_en=1 and rsv_addr=k: busy[k] <= 1.
  - Else if wr_en=1 and wr_addr=k: busy[k] <= 0.
  - Else hold.
  - Simultaneous reserve and write to the same k: reserve wins, busy stays 1 (a new producer was issued).
  - Reserve or write to different registers in one cycle: both take effect.
- ZERO_REG=1: busy[0] is constantly 0; rsv to 0 is ignored.
- rd_busy[i], on posedge with rd_en=1: rd_busy[i] <= busy[a] & ~(wr_en & wr_addr==a), forced to 0 for a hardwired zero register.
  - The bypass releases the hazard in the same cycle.
  - A same-cycle reserve is not visible to that read.
- busy_vec is the registered scoreboard state, with no combinational path from inputs.
- Reserving an already-busy register is legal; it stays busy, with no error or counter.
- Writing a non-busy register is legal: data is stored and busy stays 0.
- Out-of-range addresses cannot occur (DEPTH = 2**ADDR_W).

Decomposition:
- Shared package risc_pkg holds:
  - default DATA_W/ADDR_W constants
  - REG_ZERO address constant
  - reg_addr_t / reg_data_t typedefs, reused by decode and writeback
- Sub-module risc_scoreboard holds the DEPTH-bit busy vector, rsv/release priority, and the ZERO_REG mask. It outputs busy_vec; the top computes rd_busy from it.
- The storage array, bypass mux and read registers live in the top-level risc_regfile_sb.

Test Plan:
- Reset: write 16'hBEEF to r5, then drive reset=0 mid-cycle. Expect rd_data=0 and busy_vec=0 immediately (async). After release, a read of r5 returns 16'h0000.
- Basic/read-independence: write r3=16'h1234 with rd_en=0 (rd_data unchanged). Next cycle, rd_en=1 with rd_addr={r3,r3} and wr_en=0. Expect both ports = 16'h1234 one cycle later.
- Bypass: in one cycle, wr_en=1 to r7=16'hA5A5 and rd_en=1 with rd_addr port0=r7, port1=r2 (r2=16'h0042). Expect port0=16'hA5A5, port1=16'h0042 next cycle, and r7 stores 16'hA5A5.
- Zero register (ZERO_REG=1): write r0=16'hFFFF and rsv r0. Expect a read of r0 = 0, busy_vec[0]=0 and rd_busy=0. Repeat with ZERO_REG=0: expect read = 16'hFFFF.
- Scoreboard: rsv r4, then a read of r4 gives rd_busy[0]=1. Writeback r4=16'h0009 with a same-cycle read of r4 gives data 16'h0009 and rd_busy=0. Same-cycle rsv+wr to r6 leaves busy_vec[6]=1.
- Parameter sweep: DATA_W=32, ADDR_W=5, NUM_RD=3. Write r31=32'hDEADBEEF and read it on all 3 ports. Expect all three ports = 32'hDEADBEEF and busy_vec width 32.
